// File: rtl/ifetch_ctrl_pkg.sv
// Shared defaults and credit helper for the fetch sequencer and its response queue.
package ifetch_ctrl_pkg;

  localparam int unsigned ADDR_DEF     = 32;
  localparam int unsigned INST_DEF     = 32;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned QDEPTH       = 2;
  localparam int unsigned CNT_W        = 2;

  // A new read may issue only if queued + in-flight entries, less this cycle's pop, leave a free slot.
  function automatic logic has_credit(input logic [CNT_W-1:0] count, input logic inflight,
                                      input logic pop);
    return (3'(count) + 3'(inflight)) < (3'(QDEPTH) + 3'(pop));
  endfunction

endpackage

// File: rtl/ifetch_ctrl_fetch_buf.sv
// Two-entry FIFO of {pc, inst} fetch responses with synchronous flush.
module fetch_buf
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [QDEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c;
  logic             do_pop_c;

  always_comb begin
    do_push_c = push_i & ~flush_i;
    do_pop_c  = pop_i & ~flush_i & (count_q != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      assert (!(do_push_c && !do_pop_c && count_q == CNT_W'(QDEPTH)))
        else $error("fetch_buf overflow");
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues 1-cycle-latency imem reads, queues responses for decode.
module ifetch_ctrl
  import ifetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR     = ADDR_DEF,
  parameter int unsigned INST     = INST_DEF,
  parameter int unsigned RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic [ADDR-1:0] baddr_i,
  output logic            imem_re_o,
  output logic [ADDR-1:0] imem_addr_o,
  input  logic [INST-1:0] imem_data_i,
  output logic            v_o,
  output logic [INST-1:0] inst_o,
  output logic [ADDR-1:0] pc_o
);

  logic [ADDR-1:0]      pc_q, pc_d;
  logic [ADDR-1:0]      req_addr_q, req_addr_d;
  logic                 inflight_q, inflight_d;
  logic [CNT_W-1:0]     count;
  logic [ADDR+INST-1:0] head;
  logic                 pop_c;
  logic                 issue_c;
  logic                 redirect_c;
  logic                 push_c;

  // Redirects bypass credit because the queue and any older response are discarded this edge.
  always_comb begin
    pop_c       = v_o & ~stall_i;
    issue_c     = rst & v_i & has_credit(count, inflight_q, pop_c);
    redirect_c  = rst & v_i & branch_i;
    imem_addr_o = branch_i ? baddr_i : pc_q;
    imem_re_o   = issue_c | redirect_c;
    push_c      = rst & inflight_q & ~branch_i;
  end

  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inflight_d = imem_re_o;
    if (imem_re_o) begin
      pc_d       = imem_addr_o + ADDR'(1);
      req_addr_d = imem_addr_o;
    end else if (branch_i) begin
      pc_d = baddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= ADDR'(RESET_PC);
      req_addr_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_buf #(
    .W(ADDR + INST)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c & ~branch_i),
    .flush_i (branch_i),
    .data_i  ({req_addr_q, imem_data_i}),
    .head_o  (head),
    .count_o (count)
  );

  assign v_o    = (count != '0);
  assign inst_o = head[INST-1:0];
  assign pc_o   = head[ADDR+INST-1:INST];

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl: two instances (32-bit PC, and 4-bit PC starting at 15) against a queue model.
module tb_ifetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v_i, stall_i, branch_i;
  logic [31:0] baddr;

  logic        re0, v0;
  logic [31:0] addr0, data0, inst0, pc0;
  logic        re1, v1;
  logic [3:0]  addr1, pc1;
  logic [31:0] data1, inst1;

  ifetch_ctrl #(.ADDR(32), .INST(32), .RESET_PC(0)) dut0 (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i), .branch_i(branch_i),
    .baddr_i(baddr), .imem_re_o(re0), .imem_addr_o(addr0), .imem_data_i(data0),
    .v_o(v0), .inst_o(inst0), .pc_o(pc0)
  );

  ifetch_ctrl #(.ADDR(4), .INST(32), .RESET_PC(15)) dut1 (
    .clk(clk), .rst(rst), .v_i(v_i), .stall_i(stall_i), .branch_i(branch_i),
    .baddr_i(baddr[3:0]), .imem_re_o(re1), .imem_addr_o(addr1), .imem_data_i(data1),
    .v_o(v1), .inst_o(inst1), .pc_o(pc1)
  );

  // Instruction memory: mem[k] = 0x100 + k one cycle after a read, junk otherwise.
  always @(posedge clk) begin
    data0 <= re0 ? 32'h100 + addr0 : $urandom;
    data1 <= re1 ? 32'h100 + {28'b0, addr1} : $urandom;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", name, idx, $time, got, exp);
    end
  endtask

  // Reference model: pcs of queued instructions, one pending read, the PC.
  int unsigned m_pc[2];
  int unsigned m_q[2][3];
  int          m_n[2];
  bit          m_pend[2];
  int unsigned m_paddr[2];
  bit          e_re[2];
  int unsigned e_addr[2];
  bit          synced = 1'b0;
  bit          cur_r, cur_s, cur_b;
  logic [31:0] cur_ba;

  function automatic int unsigned amask(input int idx);
    return (idx == 0) ? 32'hFFFF_FFFF : 32'h0000_000F;
  endfunction

  function automatic int unsigned rpc(input int idx);
    return (idx == 0) ? 0 : 15;
  endfunction

  task automatic drive(input bit r, input bit v, input bit s, input bit b, input logic [31:0] ba);
    bit          pop;
    logic        g_v, g_re;
    logic [31:0] g_pc, g_inst, g_addr;
    @(negedge clk);
    rst = r; v_i = v; stall_i = s; branch_i = b; baddr = ba;
    cur_r = r; cur_s = s; cur_b = b; cur_ba = ba;
    #1;
    for (int i = 0; i < 2; i++) begin
      pop       = (m_n[i] > 0) && !s;
      e_re[i]   = r && v && (b || (m_n[i] + int'(m_pend[i]) < 2 + int'(pop)));
      e_addr[i] = b ? (ba & amask(i)) : m_pc[i];
      g_v    = (i == 0) ? v0 : v1;
      g_re   = (i == 0) ? re0 : re1;
      g_pc   = (i == 0) ? pc0 : {28'b0, pc1};
      g_inst = (i == 0) ? inst0 : inst1;
      g_addr = (i == 0) ? addr0 : {28'b0, addr1};
      if (synced) begin
        chk("v_o", i, {31'b0, g_v}, {31'b0, m_n[i] > 0});
        if (m_n[i] > 0) begin
          chk("pc_o", i, g_pc, m_q[i][0]);
          chk("inst_o", i, g_inst, 32'h100 + m_q[i][0]);
        end
        chk("imem_re_o", i, {31'b0, g_re}, {31'b0, e_re[i]});
        if (e_re[i]) chk("imem_addr_o", i, g_addr, e_addr[i]);
      end
    end
  endtask

  task automatic step();
    bit pop;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!cur_r) begin
        m_n[i] = 0; m_pend[i] = 1'b0; m_pc[i] = rpc(i); synced = 1'b1;
      end else begin
        pop = (m_n[i] > 0) && !cur_s;
        if (cur_b) m_n[i] = 0;
        else begin
          if (pop) begin
            m_q[i][0] = m_q[i][1]; m_q[i][1] = m_q[i][2]; m_n[i]--;
          end
          if (m_pend[i] && m_n[i] < 3) begin
            m_q[i][m_n[i]] = m_paddr[i]; m_n[i]++;
          end
        end
        if (e_re[i]) m_pc[i] = (e_addr[i] + 1) & amask(i);
        else if (cur_b) m_pc[i] = cur_ba & amask(i);
        m_pend[i]  = e_re[i];
        m_paddr[i] = e_addr[i];
      end
    end
  endtask

  task automatic run(input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      drive(1, 1, s, 0, 0);
      step();
    end
  endtask

  initial begin
    // Reset state
    drive(0, 1, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0);
    chk("rst_re", 0, {31'b0, re0}, 0);
    chk("rst_v", 0, {31'b0, v0}, 0);
    chk("rst_pc_o", 0, pc0, 0);
    chk("rst_inst_o", 0, inst0, 0);
    chk("rst_pc_o", 1, {28'b0, pc1}, 0);
    step();

    // Streaming from RESET_PC; 4-bit instance wraps 15 -> 0 -> 1
    drive(1, 1, 0, 0, 0); chk("c0_re", 0, {31'b0, re0}, 1); chk("c0_addr", 0, addr0, 0);
    chk("c0_v", 0, {31'b0, v0}, 0); step();
    drive(1, 1, 0, 0, 0); chk("c1_addr", 0, addr0, 1); chk("c1_v", 0, {31'b0, v0}, 0); step();
    drive(1, 1, 0, 0, 0); chk("c2_v", 0, {31'b0, v0}, 1); chk("c2_pc", 0, pc0, 0);
    chk("c2_inst", 0, inst0, 32'h100); chk("c2_pc", 1, {28'b0, pc1}, 15);
    chk("c2_inst", 1, inst1, 32'h10F); step();
    drive(1, 1, 0, 0, 0); chk("c3_pc", 0, pc0, 1); chk("wrap_pc", 1, {28'b0, pc1}, 0); step();
    drive(1, 1, 0, 0, 0); chk("c4_pc", 0, pc0, 2); chk("wrap_pc1", 1, {28'b0, pc1}, 1); step();

    // Stall 3 cycles at pc_o=3: output held, reads stop at 2 credits
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 0, 0);
      chk("stall_pc", 0, pc0, 3); chk("stall_inst", 0, inst0, 32'h103);
      chk("stall_re", 0, {31'b0, re0}, 0);
      step();
    end
    drive(1, 1, 0, 0, 0); chk("rel_pc3", 0, pc0, 3); step();

    // Redirect to 2 while the stream is at 6
    drive(1, 1, 0, 1, 2); chk("br_pc", 0, pc0, 4); chk("br_re", 0, {31'b0, re0}, 1);
    chk("br_addr", 0, addr0, 2); step();
    drive(1, 1, 0, 0, 0); chk("br_v_next", 0, {31'b0, v0}, 0); step();
    drive(1, 1, 0, 0, 0); chk("br_pc2", 0, pc0, 2); chk("br_inst2", 0, inst0, 32'h102); step();
    drive(1, 1, 0, 0, 0); chk("br_pc3", 0, pc0, 3); step();
    drive(1, 1, 0, 0, 0); chk("br_pc4", 0, pc0, 4); step();

    // Redirect to 9 while stalled with a full queue
    run(1, 4);
    drive(1, 1, 1, 1, 9); chk("bs_addr", 0, addr0, 9); step();
    drive(1, 1, 1, 0, 0); chk("bs_v_next", 0, {31'b0, v0}, 0); step();
    drive(1, 1, 1, 0, 0); chk("bs_pc9", 0, pc0, 9); chk("bs_inst9", 0, inst0, 32'h109); step();
    run(0, 3);

    // Reset pulse with a read in flight
    drive(0, 1, 0, 0, 0); chk("mr_re", 0, {31'b0, re0}, 0); step();
    drive(1, 1, 0, 0, 0); chk("mr_v", 0, {31'b0, v0}, 0); chk("mr_addr", 0, addr0, 0); step();
    drive(1, 1, 0, 0, 0); chk("mr_v1", 0, {31'b0, v0}, 0); step();
    drive(1, 1, 0, 0, 0); chk("mr_pc", 0, pc0, 0); chk("mr_inst", 0, inst0, 32'h100); step();

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      bit r, v, s, b;
      logic [31:0] ba;
      r  = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 3) == 0);
      b  = ($urandom_range(0, 11) == 0);
      ba = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      drive(r, v, s, b, ba);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
